// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative unsigned multiply/divide unit feeding the register file write
//   port. One operand bit is retired per clock: shift-add multiply (LSB first)
//   or restoring divide (MSB first).
//
// Ports
//   CLK          in   clock, rising edge
//   RST          in   asynchronous active-high reset
//   start        in   request a new operation (sampled only while idle)
//   op[1:0]      in   00 MULLO, 01 MULHI, 10 DIVU, 11 REMU
//   a, b         in   operands (rs_val / rt_val)
//   dest         in   destination register index
//   busy         out  high whenever the FSM is not idle
//   done         out  one-cycle completion pulse, result valid while high
//   reg_write_en out  register file write enable, identical to done
//   result       out  registered result (reg_in)
//   result_rd    out  destination index latched at start (rd)
// -----------------------------------------------------------------------------
`ifndef RegWidth
`define RegWidth 16
`endif
`ifndef NumRegsWidth
`define NumRegsWidth 4
`endif

module muldiv_unit #(
  parameter int WIDTH = `RegWidth,
  parameter int IDX_W = `NumRegsWidth
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [IDX_W-1:0] dest,
  output logic             busy,
  output logic             done,
  output logic             reg_write_en,
  output logic [WIDTH-1:0] result,
  output logic [IDX_W-1:0] result_rd
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [IDX_W-1:0]   r_dest;
  logic               r_dz;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_result;
  logic [IDX_W-1:0]   r_result_rd;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH:0]     w_msum;
  logic [2*WIDTH-1:0] w_prod_next;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_keep;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;
  logic [WIDTH-1:0]   w_result_final;

  assign w_accept = (r_state == IDLE) && start;
  // A divide by zero finishes on its first RUN edge without iterating, so its
  // strobe lands one cycle after the start edge.
  assign w_last   = r_dz || (r_cnt == LAST_CNT);

  // Shift-add multiply: multiplier sits in the low half and is consumed LSB
  // first while the partial product grows down from the top half.
  assign w_msum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_a} : '0);
  assign w_prod_next = {w_msum, r_prod[WIDTH-1:1]};

  // Restoring divide: dividend shifts out of r_quo MSB first into the partial
  // remainder while quotient bits shift in at the bottom.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_b};
  assign w_keep     = ~w_diff[WIDTH];
  assign w_rem_next = w_keep ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_keep};

  always_comb begin
    w_result_final = '0;
    if (r_dz) begin
      w_result_final = r_op[0] ? r_a : '1;
    end else begin
      case (r_op)
        2'b00:   w_result_final = w_prod_next[WIDTH-1:0];
        2'b01:   w_result_final = w_prod_next[2*WIDTH-1:WIDTH];
        2'b10:   w_result_final = w_quo_next;
        default: w_result_final = w_rem_next;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = RUN;
      RUN:     if (w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_dest      <= '0;
      r_dz        <= 1'b0;
      r_cnt       <= '0;
      r_prod      <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_result    <= '0;
      r_result_rd <= '0;
    end else if (w_accept) begin
      r_op   <= op;
      r_a    <= a;
      r_b    <= b;
      r_dest <= dest;
      r_dz   <= op[1] && (b == '0);
      r_cnt  <= '0;
      r_prod <= {{WIDTH{1'b0}}, b};
      r_rem  <= '0;
      r_quo  <= a;
    end else if (r_state == RUN) begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_prod <= w_prod_next;
      r_rem  <= w_rem_next;
      r_quo  <= w_quo_next;
      if (w_last) begin
        r_result    <= w_result_final;
        r_result_rd <= r_dest;
      end
    end
  end

  assign busy         = (r_state != IDLE);
  assign done         = (r_state == DONE);
  assign reg_write_en = (r_state == DONE);
  assign result       = r_result;
  assign result_rd    = r_result_rd;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed scoreboard bench for muldiv_unit. Stimulus pushes the expected
//   result, destination and completion edge; a negedge monitor pops and
//   compares each time done is seen.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int W = 16;
  localparam int I = 4;

  logic         CLK;
  logic         RST;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [I-1:0] dest;
  logic         busy;
  logic         done;
  logic         reg_write_en;
  logic [W-1:0] result;
  logic [I-1:0] result_rd;

  muldiv_unit #(.WIDTH(W), .IDX_W(I)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .start        (start),
    .op           (op),
    .a            (a),
    .b            (b),
    .dest         (dest),
    .busy         (busy),
    .done         (done),
    .reg_write_en (reg_write_en),
    .result       (result),
    .result_rd    (result_rd)
  );

  typedef struct {
    logic [W-1:0] res;
    logic [I-1:0] rd;
    int           edge_no;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  // Monitor: every done pulse must match the oldest expected entry.
  always @(negedge CLK) begin
    if (done === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done result=%h rd=%0d edge=%0d", result, result_rd, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (result !== e.res || result_rd !== e.rd || reg_write_en !== 1'b1 || cyc != e.edge_no) begin
          n_bad++;
          $display("FAIL %s got result=%h rd=%0d wen=%b edge=%0d, required result=%h rd=%0d wen=1 edge=%0d",
                   e.name, result, result_rd, reg_write_en, cyc, e.res, e.rd, e.edge_no);
        end else begin
          $display("txn %s result=%h rd=%0d edge=%0d ok", e.name, result, result_rd, cyc);
        end
      end
    end
  end

  task automatic push(input logic [W-1:0] res, input logic [I-1:0] rd, input int lat, input string name);
    exp_t e;
    e.res     = res;
    e.rd      = rd;
    e.edge_no = cyc + 1 + lat;
    e.name    = name;
    sb.push_back(e);
  endtask

  task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [I-1:0] d);
    op    = o;
    a     = x;
    b     = y;
    dest  = d;
    start = 1'b1;
  endtask

  // Called at a negedge; returns at the first negedge with busy low so the
  // next call issues at the minimum interval.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [I-1:0] d, input logic [W-1:0] res, input int lat,
                       input bit hold, input string name);
    int nb;
    push(res, d, lat, name);
    start_op(o, x, y, d);
    @(negedge CLK);
    if (!hold) start = 1'b0;
    op = ~o;
    a  = ~x;
    b  = x ^ y;
    nb = 0;
    while (busy === 1'b1 && nb < 40) begin
      nb++;
      @(negedge CLK);
    end
    start = 1'b0;
    n_cmp++;
    if (nb != lat + 1) begin
      n_bad++;
      $display("FAIL %s_busy_len got %0d cycles, required %0d", name, nb, lat + 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    RST = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; dest = '0;

    // Mid-cycle asynchronous reset, no edge in between.
    #2 RST = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || reg_write_en !== 1'b0 || result !== '0 || result_rd !== '0) begin
      n_bad++;
      $display("FAIL reset_async busy=%b done=%b wen=%b result=%h rd=%0d, required all 0",
               busy, done, reg_write_en, result, result_rd);
    end
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    issue(2'b00, 16'd3,    16'd5,    4'd3,  16'd15,   16, 1'b0, "mullo_3x5");
    issue(2'b00, 16'hFFFF, 16'hFFFF, 4'd1,  16'h0001, 16, 1'b0, "mullo_ffff");
    issue(2'b01, 16'hFFFF, 16'hFFFF, 4'd2,  16'hFFFE, 16, 1'b0, "mulhi_ffff");
    issue(2'b01, 16'h1234, 16'h0000, 4'd4,  16'h0000, 16, 1'b0, "mulhi_x0");
    issue(2'b00, 16'h1234, 16'h0010, 4'd5,  16'h2340, 16, 1'b0, "mullo_x10");
    issue(2'b01, 16'h1234, 16'h0010, 4'd6,  16'h0001, 16, 1'b0, "mulhi_x10");
    issue(2'b10, 16'd100,  16'd7,    4'd7,  16'd14,   16, 1'b1, "divu_100_7");
    issue(2'b11, 16'd100,  16'd7,    4'd8,  16'd2,    16, 1'b0, "remu_100_7");
    issue(2'b10, 16'd5,    16'd9,    4'd9,  16'd0,    16, 1'b0, "divu_5_9");
    issue(2'b11, 16'd5,    16'd9,    4'd10, 16'd5,    16, 1'b0, "remu_5_9");
    issue(2'b10, 16'hFFFF, 16'h0010, 4'd11, 16'h0FFF, 16, 1'b0, "divu_ffff_10");
    issue(2'b11, 16'hFFFF, 16'h0010, 4'd12, 16'h000F, 16, 1'b0, "remu_ffff_10");
    issue(2'b10, 16'h1234, 16'h0000, 4'd13, 16'hFFFF, 1,  1'b0, "divu_by0");
    issue(2'b11, 16'h1234, 16'h0000, 4'd14, 16'h1234, 1,  1'b0, "remu_by0");

    // Start pulse mid-run with changed operands must be ignored.
    k = cyc + 1;
    push(16'd42, 4'd5, 16, "rob_mullo_6x7");
    start_op(2'b00, 16'd6, 16'd7, 4'd5);
    @(negedge CLK);
    start = 1'b0;
    while (cyc < k + 3) @(negedge CLK);
    start_op(2'b10, 16'd0, 16'd0, 4'd9);
    @(negedge CLK);
    start = 1'b0;
    while (busy === 1'b1 && cyc < k + 40) @(negedge CLK);
    repeat (4) @(negedge CLK);

    // Reset in the middle of RUN: no strobe, outputs cleared.
    k = cyc + 1;
    start_op(2'b00, 16'd6, 16'd7, 4'd6);
    @(negedge CLK);
    start = 1'b0;
    while (cyc < k + 7) @(negedge CLK);
    RST = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      n_bad++;
      $display("FAIL reset_midrun busy=%b done=%b result=%h, required 0 0 0000", busy, done, result);
    end
    @(negedge CLK);
    RST = 1'b0;
    while (cyc <= k + 20) begin
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || reg_write_en !== 1'b0 || result !== '0 || result_rd !== '0) begin
        n_bad++;
        $display("FAIL post_reset_edge%0d busy=%b done=%b wen=%b result=%h rd=%0d, required all 0",
                 cyc - k, busy, done, reg_write_en, result, result_rd);
      end
      @(negedge CLK);
    end

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got %0d pending, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
